// File: rtl/seed_gen_pkg.sv
// Shared types and helpers for the seed generator: FSM states, basis modes and bit reversal.
package seed_gen_pkg;

  typedef enum logic [1:0] {SG_IDLE, SG_BUILD, SG_VALID} sg_state_t;

  localparam logic MODE_COUNTER = 1'b0;
  localparam logic MODE_LFSR    = 1'b1;

  // Reverses the low w bits of v; w may not exceed 64.
  function automatic logic [63:0] bit_rev(input logic [63:0] v, input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < w; i++) begin
      r[6'(w - 1 - i)] = v[6'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/seed_basis_gen.sv
// Free-running basis register: wrapping counter or Galois LFSR, selected every cycle.
// With SEED_GEN_ENTROPY_EN defined, an entropy bit is XORed into bit 0 after each update.
module seed_basis_gen
  import seed_gen_pkg::*;
#(
  parameter int unsigned        BASIS_W   = 8,
  parameter logic [BASIS_W-1:0] LFSR_TAPS = BASIS_W'(8'hB8)
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic               mode_i,
`ifdef SEED_GEN_ENTROPY_EN
  input  logic               entropy_i,
`endif
  output logic [BASIS_W-1:0] basis_o
);

  logic [BASIS_W-1:0] basis_q;
  logic [BASIS_W-1:0] basis_d;
  logic [BASIS_W-1:0] step;

  // Zero-escape decision is taken on the register value, before any entropy mixing.
  always_comb begin
    step = basis_q;
    if (mode_i == MODE_COUNTER) begin
      step = (&basis_q) ? '0 : basis_q + BASIS_W'(1);
    end else if (basis_q == '0) begin
      step = BASIS_W'(1);
    end else begin
      step = (basis_q >> 1) ^ (basis_q[0] ? LFSR_TAPS : '0);
    end
    basis_d = step;
`ifdef SEED_GEN_ENTROPY_EN
    basis_d[0] = step[0] ^ entropy_i;
`endif
  end

  always_ff @(posedge clk) begin
    if (clr_i) basis_q <= '0;
    else       basis_q <= basis_d;
  end

  assign basis_o = basis_q;

endmodule

// File: rtl/seed_gen_param.sv
// Seed generator top: snapshots the basis on req, expands it into SEED_W bits, valid/ack handshake.
// Optional entropy input enabled by defining SEED_GEN_ENTROPY_EN.
module seed_gen_param
  import seed_gen_pkg::*;
#(
  parameter int unsigned        BASIS_W   = 8,
  parameter int unsigned        SEED_W    = 32,
  parameter logic [BASIS_W-1:0] LFSR_TAPS = BASIS_W'(8'hB8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rst_seedgen,
  input  logic              mode,
  input  logic              req,
  input  logic              ack,
`ifdef SEED_GEN_ENTROPY_EN
  input  logic              entropy,
`endif
  output logic              busy,
  output logic              seed_valid,
  output logic [SEED_W-1:0] seed
);

  localparam int unsigned CHUNKS = SEED_W / BASIS_W;
  localparam int unsigned IDX_W  = $clog2(CHUNKS + 1);

  sg_state_t          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BASIS_W-1:0] snap_q, snap_d;
  logic [SEED_W-1:0]  shadow_q, shadow_d;
  logic [SEED_W-1:0]  seed_q, seed_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [BASIS_W-1:0] basis;
  logic [BASIS_W-1:0] snap_rev;
  logic               clr;

  assign clr = reset | rst_seedgen;

  seed_basis_gen #(
    .BASIS_W   (BASIS_W),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_basis (
    .clk       (clk),
    .clr_i     (clr),
    .mode_i    (mode),
`ifdef SEED_GEN_ENTROPY_EN
    .entropy_i (entropy),
`endif
    .basis_o   (basis)
  );

  assign snap_rev = BASIS_W'(bit_rev(64'(snap_q), BASIS_W));

  // Slices fill MSB-first, one per cycle; the extra idx==CHUNKS cycle commits the shadow.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    snap_d   = snap_q;
    shadow_d = shadow_q;
    seed_d   = seed_q;
    valid_d  = valid_q;
    busy_d   = 1'b0;
    case (state_q)
      SG_IDLE: begin
        if (req) begin
          snap_d  = basis;
          idx_d   = '0;
          state_d = SG_BUILD;
          busy_d  = 1'b1;
        end
      end
      SG_BUILD: begin
        if (idx_q == IDX_W'(CHUNKS)) begin
          seed_d  = shadow_q;
          valid_d = 1'b1;
          state_d = SG_VALID;
        end else begin
          for (int unsigned k = 0; k < CHUNKS; k++) begin
            if (idx_q == IDX_W'(k)) begin
              shadow_d[(CHUNKS-1-k)*BASIS_W +: BASIS_W] = (k % 2 == 0) ? snap_rev : snap_q;
            end
          end
          idx_d  = idx_q + IDX_W'(1);
          busy_d = (idx_q != IDX_W'(CHUNKS - 1));
        end
      end
      SG_VALID: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = SG_IDLE;
        end
      end
      default: state_d = SG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= SG_IDLE;
      idx_q    <= '0;
      snap_q   <= '0;
      shadow_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      snap_q   <= snap_d;
      shadow_q <= shadow_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  // Soft clear keeps the last delivered seed; only the hard reset zeroes it.
  always_ff @(posedge clk) begin
    if (reset)             seed_q <= '0;
    else if (!rst_seedgen) seed_q <= seed_d;
  end

  assign busy       = busy_q;
  assign seed_valid = valid_q;
  assign seed       = seed_q;

endmodule

// File: tb/tb_seed_gen_param.sv
// Scoreboard bench for seed_gen_param: arithmetic reference model, directed cases, random traffic.
`timescale 1ns/1ps
module tb_seed_gen_param;

  localparam int unsigned BASIS_W = 8;
  localparam int unsigned SEED_W  = 32;
  localparam int unsigned CHUNKS  = SEED_W / BASIS_W;
  localparam int unsigned TAPS    = 32'hB8;
`ifdef SEED_GEN_ENTROPY_EN
  localparam bit ENT_ON = 1'b1;
`else
  localparam bit ENT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1, rst_seedgen = 1'b0, mode = 1'b0, req = 1'b0, ack = 1'b0, entropy = 1'b0;
  logic busy, seed_valid;
  logic [SEED_W-1:0] seed;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seed_gen_param dut (
    .clk         (clk),
    .reset       (reset),
    .rst_seedgen (rst_seedgen),
    .mode        (mode),
    .req         (req),
    .ack         (ack),
`ifdef SEED_GEN_ENTROPY_EN
    .entropy     (entropy),
`endif
    .busy        (busy),
    .seed_valid  (seed_valid),
    .seed        (seed)
  );

  // ---------------- reference model ----------------
  int unsigned m_basis = 0;
  int unsigned cyc = 0;
  int unsigned m_due = 0;
  bit          m_inflight = 0, m_valid = 0, m_busy = 0, chk_en = 0;
  logic [31:0] m_seed = '0, m_pending = '0;
  logic [31:0] exp_q[$];

  function automatic int unsigned rev8(input int unsigned b);
    int unsigned r = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) r |= (1 << (7 - i));
    return r;
  endfunction

  function automatic logic [31:0] expand(input int unsigned b);
    logic [31:0] s = '0;
    for (int k = 0; k < int'(CHUNKS); k++)
      s = (s << 8) | 32'((k % 2 == 0) ? rev8(b) : b);
    return s;
  endfunction

  function automatic int unsigned next_basis(input int unsigned b, input logic md, input logic e);
    int unsigned nb;
    if (md == 1'b0)  nb = (b + 1) % 256;
    else if (b == 0) nb = 1;
    else             nb = (b >> 1) ^ (((b & 1) != 0) ? TAPS : 0);
    if (ENT_ON && e) nb = nb ^ 1;
    return nb;
  endfunction

  always @(posedge clk) begin
    int unsigned nb;
    cyc++;
    nb = next_basis(m_basis, mode, entropy);
    if (reset || rst_seedgen) begin
      m_basis = 0; m_valid = 0; m_inflight = 0;
      exp_q.delete();
      if (reset) m_seed = '0;
    end else begin
      if (m_valid) begin
        if (ack) m_valid = 0;
      end else if (m_inflight) begin
        if (cyc == m_due) begin
          m_valid = 1; m_inflight = 0; m_seed = m_pending;
          exp_q.push_back(m_pending);
        end
      end else if (req) begin
        m_pending = expand(m_basis);
        m_inflight = 1;
        m_due = cyc + CHUNKS + 1;
      end
      m_basis = nb;
    end
    m_busy = m_inflight && (cyc + 2 <= m_due);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mon_valid", 32'(seed_valid), 32'(m_valid));
      chk("mon_busy", 32'(busy), 32'(m_busy));
      chk("mon_seed", seed, m_seed);
      if (seed_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_seed", 32'(seed_valid), 32'd0);
        else chk("sb_seed", seed, exp_q.pop_front());
      end
    end
    prev_valid = seed_valid;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_basis(input int unsigned target);
    for (int i = 0; i < 600; i++) begin
      if (m_basis == target) return;
      step();
    end
    chk("wait_basis_timeout", m_basis, target);
  endtask

  task automatic wait_valid(input string name, output int bcnt);
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bcnt++;
      if (seed_valid) return;
      step();
    end
    chk(name, 32'(seed_valid), 32'd1);
  endtask

  task automatic do_ack();
    ack = 1'b1; step(); ack = 1'b0;
  endtask

  task automatic pulse_req();
    req = 1'b1; step(); req = 1'b0;
  endtask

  initial begin
    int bcnt;
    reset = 1'b1;
    repeat (3) step();
    chk_en = 1;
    chk("rst_seed", seed, 32'd0);
    chk("rst_valid", 32'(seed_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0; mode = 1'b0;

    // counter slice pattern + handshake
    wait_basis(32'h02);
    pulse_req();
    wait_valid("cnt_valid_timeout", bcnt);
    chk("cnt_busy_cycles", 32'(bcnt), 32'd4);
    chk("cnt_seed", seed, 32'h40024002);
    for (int i = 0; i < 10; i++) begin
      req = 1'($urandom_range(0, 1));
      step();
      chk("hold_seed", seed, 32'h40024002);
      chk("hold_valid", 32'(seed_valid), 32'd1);
    end
    req = 1'b0;
    do_ack();
    chk("ack_valid_low", 32'(seed_valid), 32'd0);
    chk("ack_seed_keep", seed, 32'h40024002);
    repeat (8) step();
    chk("no_second_valid", 32'(seed_valid), 32'd0);

    // counter wrap
    wait_basis(32'hFF);
    pulse_req();
    wait_valid("wrap_valid_timeout", bcnt);
    chk("wrap_seed", seed, 32'hFFFFFFFF);
    do_ack();

    // LFSR from zero
    reset = 1'b1; step(); reset = 1'b0; mode = 1'b1;
    chk("lfsr_rst_seed", seed, 32'd0);
    wait_basis(32'hB8);
    pulse_req();
    wait_valid("lfsr_valid_timeout", bcnt);
    chk("lfsr_seed", seed, 32'h1DB81DB8);
    do_ack();

    // soft abort mid-build, then basis restarts from zero
    mode = 1'b0;
    pulse_req();
    step();
    rst_seedgen = 1'b1; step(); rst_seedgen = 1'b0;
    chk("soft_abort_valid", 32'(seed_valid), 32'd0);
    chk("soft_abort_busy", 32'(busy), 32'd0);
    chk("soft_abort_seed", seed, 32'h1DB81DB8);
    pulse_req();
    wait_valid("post_abort_timeout", bcnt);
    chk("post_abort_seed", seed, 32'h00000000);
    do_ack();

    // hard abort clears seed
    wait_basis(32'h05);
    pulse_req();
    wait_valid("pre_hard_timeout", bcnt);
    do_ack();
    pulse_req(); step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("hard_abort_seed", seed, 32'd0);
    chk("hard_abort_valid", 32'(seed_valid), 32'd0);

    // entropy bit mixed into the counter update
    wait_basis(32'h10);
    entropy = 1'b1; step(); entropy = 1'b0;
    pulse_req();
    wait_valid("ent_valid_timeout", bcnt);
    chk("ent_seed", seed, ENT_ON ? 32'h08100810 : 32'h88118811);
    do_ack();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      mode        = 1'($urandom_range(0, 1));
      req         = ($urandom_range(0, 9) < 3);
      ack         = ($urandom_range(0, 9) < 3);
      entropy     = 1'($urandom_range(0, 1));
      rst_seedgen = ($urandom_range(0, 199) == 0);
      reset       = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0; rst_seedgen = 1'b0; req = 1'b0; ack = 1'b1; entropy = 1'b0;
    repeat (3) step();
    ack = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
